// File: rtl/pwm_pkg.sv
// Shared PWM definitions: percentage limits, FSM encoding and the percentage clamp
// that the touch-coordinate decoder also uses.
package pwm_pkg;

  localparam logic [6:0] PCT_MAX          = 7'd100;
  localparam int         STEPS_PER_PERIOD = 100;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  function automatic logic [6:0] clamp_pct(input logic [6:0] pct);
    return (pct > PCT_MAX) ? PCT_MAX : pct;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step prescaler: div_cnt runs 0..div_sh-1 while run is high and tick marks its last cycle.
module pwm_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div_sh,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;
  logic             last;

  assign last = (div_cnt == div_sh - DIV_W'(1));
  assign tick = run && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            div_cnt <= '0;
    else if (!run || last) div_cnt <= '0;
    else                   div_cnt <= div_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/pwm_generador.sv
// Double-buffered PWM generator: 100 steps per period, shadows reloaded only at
// start-up and at the step 99->0 wrap so a new setting never produces a runt pulse.
module pwm_generador
  import pwm_pkg::*;
#(
  parameter int DIV_MIN  = 5,
  parameter int DIV_STEP = 50,
  parameter int DIV_W    = 16
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       EN,
  input  logic [6:0] duty_cycle,
  input  logic [6:0] freq_porcentaje,
  output logic       PWM_OUT,
  output logic       PERIOD_START
);

  localparam longint DIV_MAX = longint'(DIV_MIN) + 64'd100 * longint'(DIV_STEP);

  generate
    if (DIV_MIN < 1 || DIV_STEP < 0 || DIV_W > 62 || DIV_MAX >= (64'd1 << DIV_W)) begin : g_bad_params
      $error("pwm_generador: DIV_W too narrow for DIV_MIN + 100*DIV_STEP, or DIV_MIN < 1");
    end
  endgenerate

  pwm_state_e       state, state_nxt;
  logic [6:0]       duty_sh, step_cnt;
  logic [DIV_W-1:0] div_sh, div_nxt;
  logic [6:0]       duty_cl, freq_cl;
  logic             run, tick, step_last, load, origin;

  assign duty_cl   = clamp_pct(duty_cycle);
  assign freq_cl   = clamp_pct(freq_porcentaje);
  assign div_nxt   = DIV_W'(DIV_MIN) + DIV_W'(PCT_MAX - freq_cl) * DIV_W'(DIV_STEP);

  // EN low in RUN clears the counters on the same edge that returns to IDLE.
  assign run       = (state == RUN) && EN;
  assign step_last = (step_cnt == 7'(STEPS_PER_PERIOD - 1));
  assign load      = ((state == IDLE) && EN) || (tick && step_last);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN)  state_nxt = RUN;
      RUN:     if (!EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  pwm_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (CLK),
    .rst_n  (RST_n),
    .run    (run),
    .div_sh (div_sh),
    .tick   (tick)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      duty_sh <= '0;
      div_sh  <= '0;
    end else if (load) begin
      duty_sh <= duty_cl;
      div_sh  <= div_nxt;
    end
  end

  // origin tracks step_cnt==0 && div_cnt==0 without exporting div_cnt from the prescaler.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      step_cnt <= '0;
      origin   <= 1'b1;
    end else begin
      origin <= !run || (tick && step_last);
      if (!run)      step_cnt <= '0;
      else if (tick) step_cnt <= step_last ? 7'd0 : step_cnt + 7'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      PWM_OUT      <= 1'b0;
      PERIOD_START <= 1'b0;
    end else begin
      PWM_OUT      <= (state == RUN) && (step_cnt < duty_sh);
      PERIOD_START <= (state == RUN) && origin;
    end
  end

endmodule

// File: tb/tb_pwm_generador.sv
// Bench for pwm_generador: a time-within-period reference model checked every cycle,
// plus directed high-time / period-count checks and randomized setting changes.
module tb_pwm_generador;

  localparam int DIV_MIN  = 2;
  localparam int DIV_STEP = 1;
  localparam int DIV_W    = 16;

  logic       CLK, RST_n, EN;
  logic [6:0] duty_cycle, freq_porcentaje;
  logic       PWM_OUT, PERIOD_START;

  pwm_generador #(.DIV_MIN(DIV_MIN), .DIV_STEP(DIV_STEP), .DIV_W(DIV_W)) dut (
    .CLK             (CLK),
    .RST_n           (RST_n),
    .EN              (EN),
    .duty_cycle      (duty_cycle),
    .freq_porcentaje (freq_porcentaje),
    .PWM_OUT         (PWM_OUT),
    .PERIOD_START    (PERIOD_START)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int n_chk = 0, n_err = 0;
  int highs = 0, starts = 0;

  // Model: running flag, cycle position t within the period, and the applied setting.
  bit m_run;
  int m_t, m_duty, m_div;
  bit exp_pwm, exp_ps;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 100) ? 100 : v;
  endfunction

  task automatic model_load();
    m_duty = clamp(int'(duty_cycle));
    m_div  = DIV_MIN + (100 - clamp(int'(freq_porcentaje))) * DIV_STEP;
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_duty = 0; m_div = 0;
    exp_pwm = 0; exp_ps = 0;
  endtask

  task automatic model_step();
    if (!RST_n) begin
      model_reset();
      return;
    end
    exp_pwm = m_run ? ((m_t / m_div) < m_duty) : 1'b0;
    exp_ps  = m_run && (m_t == 0);
    if (!m_run) begin
      if (EN) begin
        m_run = 1; m_t = 0;
        model_load();
      end
    end else if (!EN) begin
      m_run = 0; m_t = 0;
    end else begin
      m_t++;
      if (m_t == 100 * m_div) begin
        m_t = 0;
        model_load();
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    chk("pwm", 32'(PWM_OUT), 32'(exp_pwm));
    chk("ps", 32'(PERIOD_START), 32'(exp_ps));
    if (PWM_OUT === 1'b1) highs++;
    if (PERIOD_START === 1'b1) starts++;
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic start_fresh(input int d, input int f);
    EN = 1'b0;
    cycle();
    cycle();
    duty_cycle = 7'(d);
    freq_porcentaje = 7'(f);
    EN = 1'b1;
    cycle();
    highs = 0;
    starts = 0;
  endtask

  initial begin
    RST_n = 1'b0; EN = 1'b0; duty_cycle = '0; freq_porcentaje = '0;
    model_reset();
    run_n(3);
    chk("rst_pwm", 32'(PWM_OUT), 32'd0);
    chk("rst_ps", 32'(PERIOD_START), 32'd0);
    RST_n = 1'b1;
    run_n(3);
    chk("idle_pwm", 32'(PWM_OUT), 32'd0);

    // duty 33, f 100: period 200, high 66
    duty_cycle = 7'd33; freq_porcentaje = 7'd100; EN = 1'b1;
    cycle();
    highs = 0; starts = 0;
    cycle();
    chk("first_ps", 32'(PERIOD_START), 32'd1);
    chk("first_pwm", 32'(PWM_OUT), 32'd1);
    run_n(199);
    chk("d33_high", 32'(highs), 32'd66);
    chk("d33_starts", 32'(starts), 32'd1);

    // duty 50, f 0: period 10200, high 5100
    start_fresh(50, 0);
    run_n(10200);
    chk("f0_high", 32'(highs), 32'd5100);
    chk("f0_starts", 32'(starts), 32'd1);

    // mid-period change 20 -> 80
    start_fresh(20, 100);
    run_n(100);
    duty_cycle = 7'd80;
    run_n(100);
    chk("mid_cur_high", 32'(highs), 32'd40);
    highs = 0; starts = 0;
    run_n(200);
    chk("mid_next_high", 32'(highs), 32'd160);
    chk("mid_next_starts", 32'(starts), 32'd1);

    // duty 0 and duty 100 over three periods
    start_fresh(0, 100);
    run_n(600);
    chk("d0_high", 32'(highs), 32'd0);
    chk("d0_starts", 32'(starts), 32'd3);
    start_fresh(100, 100);
    run_n(600);
    chk("d100_high", 32'(highs), 32'd600);
    chk("d100_starts", 32'(starts), 32'd3);

    // out-of-range inputs clamp to 100/100
    start_fresh(120, 127);
    run_n(600);
    chk("clamp_high", 32'(highs), 32'd600);
    chk("clamp_starts", 32'(starts), 32'd3);

    // disable at cycle 30, re-enable 10 cycles later
    start_fresh(50, 100);
    run_n(30);
    EN = 1'b0;
    cycle();
    cycle();
    chk("dis_low", 32'(PWM_OUT), 32'd0);
    run_n(8);
    EN = 1'b1;
    cycle();
    cycle();
    chk("reen_ps", 32'(PERIOD_START), 32'd1);
    run_n(250);

    // async reset mid-period
    start_fresh(50, 100);
    run_n(30);
    chk("pre_rst_pwm", 32'(PWM_OUT), 32'd1);
    #3 RST_n = 1'b0;
    #1;
    chk("async_pwm", 32'(PWM_OUT), 32'd0);
    chk("async_ps", 32'(PERIOD_START), 32'd0);
    model_reset();
    run_n(2);
    RST_n = 1'b1;
    run_n(450);

    // randomized setting changes and enable drops
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: EN = ~EN;
        default: begin
          duty_cycle = 7'($urandom_range(0, 127));
          freq_porcentaje = 7'($urandom_range(85, 127));
        end
      endcase
      run_n($urandom_range(20, 1500));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
